// File: rtl/cmd_router_if.sv
// cmd_router_if: bundles the SPI command/response handshake, the per-module control links and router status.
// master: SPI port and front-end modules (drive cmd_in/cmd_valid/rsp_ready, m_cmd_ready, m_rsp/m_rsp_valid).
// slave : the router (drives cmd_ready, rsp_out/rsp_valid, m_cmd/m_cmd_valid, m_rsp_ready, busy, timeouts).
interface cmd_router_if #(
   parameter int NMOD = 4
) ();
   logic [31:0]        cmd_in;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [31:0]        rsp_out;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        m_cmd;
   logic [NMOD-1:0]    m_cmd_valid;
   logic [NMOD-1:0]    m_cmd_ready;
   logic [32*NMOD-1:0] m_rsp;
   logic [NMOD-1:0]    m_rsp_valid;
   logic [NMOD-1:0]    m_rsp_ready;
   logic               busy;
   logic [15:0]        timeouts;
   modport master (
      output cmd_in, cmd_valid, rsp_ready, m_cmd_ready, m_rsp, m_rsp_valid,
      input  cmd_ready, rsp_out, rsp_valid, m_cmd, m_cmd_valid, m_rsp_ready, busy, timeouts
   );
   modport slave (
      input  cmd_in, cmd_valid, rsp_ready, m_cmd_ready, m_rsp, m_rsp_valid,
      output cmd_ready, rsp_out, rsp_valid, m_cmd, m_cmd_valid, m_rsp_ready, busy, timeouts
   );
endinterface

// File: rtl/cmd_router.sv
// cmd_router: sequences one SPI command at a time to the front-end module links and returns one 32-bit response.
// Ports: clk; rst (synchronous, active-low); bus (cmd_router_if.slave) with SPI cmd/rsp handshakes,
// shared m_cmd with per-module valid/ready, per-module response words, busy flag and saturating timeout count.
module cmd_router #(
   parameter int NMOD    = 4,
   parameter int TIMEOUT = 100_000,
   parameter int TW      = 17
) (
   input logic         clk,
   input logic         rst,
   cmd_router_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
   state_t          state_q;
   logic            cmd_ready_q, rsp_valid_q, busy_q, bcast_q, bcast_d, inval_d, hit_d, expire_d;
   logic [31:0]     rsp_out_q, m_cmd_q, sel_d, err_d;
   logic [3:0]      id_d, tgt_q;
   logic [NMOD-1:0] m_cmd_valid_q, m_rsp_ready_q, mask_d, pend_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic [15:0]     timeouts_q, timeouts_d;
   always_comb begin
      id_d    = bus.cmd_in[31:28];
      bcast_d = id_d == 4'hF;
      mask_d  = '0;
      sel_d   = '0;
      hit_d   = 1'b0;
      for (int k = 0; k < NMOD; k++) begin
         mask_d[k] = bcast_d || id_d == 4'(k);
         if (tgt_q == 4'(k)) begin
            sel_d = bus.m_rsp[32*k +: 32];
            hit_d = bus.m_rsp_valid[k];
         end
      end
      inval_d    = mask_d == '0;
      pend_d     = m_cmd_valid_q & ~bus.m_cmd_ready;
      cnt_d      = cnt_q + 1'b1;
      // expiry on the edge where the counter would reach TIMEOUT: TIMEOUT cycles from acceptance
      expire_d   = cnt_d >= TW'(TIMEOUT);
      err_d      = {4'hE, m_cmd_q[27:0]};
      timeouts_d = timeouts_q + 16'(timeouts_q != 16'hFFFF);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_out_q     <= '0;
         m_cmd_q       <= '0;
         m_cmd_valid_q <= '0;
         m_rsp_ready_q <= '0;
         busy_q        <= 1'b0;
         timeouts_q    <= '0;
         cnt_q         <= '0;
         tgt_q         <= '0;
         bcast_q       <= 1'b0;
      end else begin
         // the target's word is captured in WAIT; in every other case responses are drained
         m_rsp_ready_q <= '1;
         case (state_q)
            IDLE: begin
               cmd_ready_q <= !(bus.cmd_valid && cmd_ready_q);
               if (bus.cmd_valid && cmd_ready_q) begin
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  tgt_q   <= id_d;
                  bcast_q <= bcast_d;
                  if (inval_d) begin
                     rsp_out_q   <= {4'hE, bus.cmd_in[27:0]};
                     rsp_valid_q <= 1'b1;
                     state_q     <= RETURN;
                  end else begin
                     m_cmd_q       <= bus.cmd_in;
                     m_cmd_valid_q <= mask_d;
                     state_q       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_q         <= cnt_d;
               m_cmd_valid_q <= pend_d;
               if (pend_d == '0) begin
                  rsp_out_q   <= m_cmd_q;
                  rsp_valid_q <= bcast_q;
                  state_q     <= bcast_q ? RETURN : WAIT;
               end else if (expire_d) begin
                  m_cmd_valid_q <= '0;
                  rsp_out_q     <= err_d;
                  rsp_valid_q   <= 1'b1;
                  timeouts_q    <= timeouts_d;
                  state_q       <= RETURN;
               end
            end
            WAIT: begin
               cnt_q <= cnt_d;
               if (hit_d || expire_d) begin
                  rsp_out_q   <= hit_d ? sel_d : err_d;
                  rsp_valid_q <= 1'b1;
                  timeouts_q  <= hit_d ? timeouts_q : timeouts_d;
                  state_q     <= RETURN;
               end
            end
            RETURN: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.rsp_out     = rsp_out_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.m_cmd       = m_cmd_q;
   assign bus.m_cmd_valid = m_cmd_valid_q;
   assign bus.m_rsp_ready = m_rsp_ready_q;
   assign bus.busy        = busy_q;
   assign bus.timeouts    = timeouts_q;
endmodule

// File: doc/cmd_router.md
Name: cmd_router

Overview:
- Sequences control commands from the gigex SPI command port out to the front-end module control links, and returns one 32-bit response per command back to the SPI port.
- Decodes the module-id field, then either drives one module (unicast) or all modules (broadcast).
- Waits for the addressed module's response and enforces a timeout.
- Sits between the SPI slave and the per-module control tx / data rx paths in backend.

Parameters:
- NMOD, 4, number of front-end modules (max 15).
- TIMEOUT, 100_000, clk cycles allowed from command acceptance to response capture.
- TW, 17, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-low.
- cmd_in  in  32  command word from SPI.
- cmd_valid  in  1  cmd_in valid.
- cmd_ready  out  1  router accepts cmd_in.
- rsp_out  out  32  response word to SPI.
- rsp_valid  out  1  rsp_out valid.
- rsp_ready  in  1  SPI has taken rsp_out.
- m_cmd  out  32  command word, shared by all module links.
- m_cmd_valid  out  NMOD  per-module command valid.
- m_cmd_ready  in  NMOD  per-module command ready.
- m_rsp  in  32*NMOD  per-module response words; module k occupies bits [32k +: 32].
- m_rsp_valid  in  NMOD  per-module response valid.
- m_rsp_ready  out  NMOD  per-module response ready.
- busy  out  1  high in any state other than IDLE.
- timeouts  out  16  saturating count of timed-out commands.

Behaviour:
- Command decode:
  - cmd_in[31:28] = module id.
  - Values 0..NMOD-1: unicast to that module.
  - 4'hF: broadcast to all modules.
  - Any other value: invalid.
- Error word: {4'hE, cmd[27:0]}.
- Reset (rst low at a clk edge):
  - State returns to IDLE; cmd_ready=0 during reset.
  - rsp_valid=0, rsp_out=0, m_cmd=0, m_cmd_valid=0, busy=0, timeouts=0, timeout counter=0.
  - Any command in flight is discarded; no response is produced for it.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cmd_in and load the counter with 0.
  - Invalid id: go to RETURN with the error word; no module is driven.
  - Otherwise: go to ISSUE.
- State ISSUE:
  - m_cmd = latched command.
  - m_cmd_valid bit k is set for the target module (unicast) or for all modules (broadcast).
  - Each bit clears individually on its m_cmd_valid[k]&m_cmd_ready[k] handshake.
  - When all bits are clear: unicast goes to WAIT; broadcast goes to RETURN with the latched command echoed as the response.
- State WAIT (unicast only):
  - m_rsp_ready[target]=1.
  - On m_rsp_valid[target], capture that word as the response and go to RETURN.
- State RETURN:
  - rsp_valid=1 with rsp_out stable.
  - On rsp_ready, deassert rsp_valid and go to IDLE.
  - Back-pressure may last indefinitely.
- Non-addressed modules:
  - m_rsp_ready[k]=1 in every state except WAIT-for-k.
  - Their responses are consumed and discarded (stale/unsolicited drain).
- Timeout:
  - The counter increments each cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT: clear all m_cmd_valid, load the error word, increment timeouts (saturate at 16'hFFFF), go to RETURN.
  - If a response handshake and expiry land in the same cycle, the response wins.
- Latency:
  - Command accepted in cycle N → m_cmd_valid high in cycle N+1.
  - Response captured in cycle M → rsp_valid high in cycle M+1.
  - Invalid id → rsp_valid in cycle N+1.
- Only one command is in flight at a time; cmd_ready=0 in every state except IDLE.
- All outputs are registered.

Test Plan:
- Unicast:
  - Stimulus: cmd 32'h1064_0011; module 1 ready immediately; module 1 returns 32'h1064_5A5A 20 cycles later.
  - Response: m_cmd_valid=4'b0010 for 1 cycle; rsp_out=32'h1064_5A5A; timeouts=0.
- Broadcast:
  - Stimulus: cmd 32'hF064_04FF; m_cmd_ready for modules 0,1,2,3 asserted at cycles 1,5,9,3 respectively.
  - Response: each valid bit drops individually; rsp_out=32'hF064_04FF one cycle after module 2's handshake; no WAIT state entered.
- Timeout:
  - Stimulus: TIMEOUT=200; cmd 32'h2064_0311; module 2 accepts the command but never responds.
  - Response: rsp_out=32'hE064_0311 about 201 cycles after acceptance; timeouts=1.
  - Follow-up: a module-2 response arriving later is drained and does not produce a response.
- Invalid id / stale drain:
  - Stimulus: cmd 32'h7064_0000 (NMOD=4), with module 3 asserting an unsolicited m_rsp_valid.
  - Response: rsp_out=32'hE064_0000 in cycle N+1; no m_cmd_valid; module 3 word consumed.
- Back-pressure:
  - Stimulus: hold rsp_ready=0 for 500 cycles during RETURN.
  - Response: rsp_out stable, cmd_ready=0; on release, a 1-cycle handshake, then IDLE.
- Reset mid-operation:
  - Stimulus: pull rst low during WAIT.
  - Response: next cycle busy=0, m_cmd_valid=0, rsp_valid=0; a subsequent unicast completes normally.
